// File: rtl/i2s_tx.sv
// i2s_tx: I2S stereo transmitter with a 256-mclk frame, a sample holding register and an underrun flag
module i2s_tx #(
  parameter int SAMPLE_BITS = 16,
  parameter int FRAME_MCLKS = 256
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SAMPLE_BITS-1:0] left_in,
  input  logic [SAMPLE_BITS-1:0] right_in,
  input  logic                   in_valid,
  output logic                   sample_req,
  output logic                   underrun,
  input  logic                   underrun_clr,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata
);
  localparam int CW = $clog2(FRAME_MCLKS);
  localparam int KW = CW - 3;
  localparam int IW = $clog2(SAMPLE_BITS);
  logic [CW-1:0] cnt;
  logic run, fresh, load, bit_n;
  logic [SAMPLE_BITS-1:0] hold_l, hold_r, sh_l, sh_r, word;
  logic [KW-1:0] k;
  // a load happens on the wrap and on the first enabled edge after idle
  always_comb begin
    load = en && (!run || cnt == CW'(FRAME_MCLKS - 1));
    k = cnt[CW-2:2];
    word = cnt[CW-1] ? sh_r : sh_l;
    bit_n = (k != '0 && k <= KW'(SAMPLE_BITS)) ? word[IW'(KW'(SAMPLE_BITS) - k)] : 1'b0;
  end
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      run        <= 1'b0;
      fresh      <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      sample_req <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      cnt        <= (!en || load) ? '0 : cnt + CW'(1);
      run        <= en;
      bclk       <= en & cnt[1];
      lrclk      <= en & cnt[CW-1];
      sdata      <= en & bit_n;
      sample_req <= load;
      if (load) begin
        sh_l <= fresh ? hold_l : '0;
        sh_r <= fresh ? hold_r : '0;
      end
      if (in_valid) begin
        hold_l <= left_in;
        hold_r <= right_in;
      end
      fresh    <= in_valid | (fresh & !load);
      underrun <= (load & !fresh) | (underrun & !underrun_clr);
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed and randomized checks of i2s_tx against a frame-level arithmetic model
module tb_i2s_tx;
  logic mclk = 0, rst = 1, en = 0, in_valid = 0, underrun_clr = 0;
  logic [15:0] left_in = 0, right_in = 0;
  logic sample_req, underrun, bclk, lrclk, sdata;
  int total = 0, passes = 0, n = 0;
  logic [15:0] hl = 0, hr = 0;
  bit fresh = 0, m_ur = 0;
  logic [31:0] frames [0:63];

  always #5 mclk = ~mclk;

  i2s_tx dut (
    .mclk(mclk), .rst(rst), .en(en), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .sample_req(sample_req), .underrun(underrun),
    .underrun_clr(underrun_clr), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b n=%0d t=%0t", tag, obs, exp, n, $time);
  endtask

  task automatic chk_out(input logic eb, input logic el, input logic es, input logic er);
    chk("bclk", bclk, eb);
    chk("lrclk", lrclk, el);
    chk("sdata", sdata, es);
    chk("sample_req", sample_req, er);
    chk("underrun", underrun, m_ur);
  endtask

  // n counts enabled edges since the last start; edge n sees cnt = (n-1) mod 256
  task automatic cyc(input logic e, input logic v, input logic [15:0] l, input logic [15:0] r, input logic c);
    bit set;
    int cc, slot;
    logic [15:0] half;
    logic eb, el, es, er;
    en = e; in_valid = v; left_in = l; right_in = r; underrun_clr = c;
    @(posedge mclk);
    set = 0; eb = 0; el = 0; es = 0; er = 0;
    if (e) begin
      if (n % 256 == 0) begin
        frames[n / 256] = fresh ? {hl, hr} : 32'h0;
        set = !fresh;
        fresh = 0;
        er = 1;
      end
      if (n > 0) begin
        cc = (n - 1) % 256;
        eb = (cc % 4) >= 2;
        el = cc >= 128;
        slot = (cc % 128) / 4;
        half = (cc >= 128) ? frames[(n - 1) / 256][15:0] : frames[(n - 1) / 256][31:16];
        es = (slot >= 1 && slot <= 16) ? half[16 - slot] : 1'b0;
      end
      n++;
    end else n = 0;
    if (v) begin hl = l; hr = r; fresh = 1; end
    if (set) m_ur = 1;
    else if (c) m_ur = 0;
    #1;
    chk_out(eb, el, es, er);
  endtask

  // mode 0: fixed pair two cycles into each frame, clear at 50; mode 1: random; mode 2: no writes
  task automatic run(input int cycles, input int mode, input logic [15:0] l, input logic [15:0] r);
    int ph;
    logic v, c;
    logic [15:0] a, b;
    for (int i = 0; i < cycles; i++) begin
      ph = n % 256; a = l; b = r; v = 0; c = 0;
      if (mode == 0) begin
        v = (ph == 2);
        c = (ph == 50);
      end else if (mode == 1) begin
        v = (ph == 2 && $urandom_range(0, 3) != 0) || $urandom_range(0, 99) == 0;
        a = 16'($urandom);
        b = 16'($urandom);
        c = $urandom_range(0, 199) == 0;
      end
      cyc(1, v, a, b, c);
    end
  endtask

  function automatic int to(input int p);
    return (p - n % 256 + 256) % 256;
  endfunction

  initial begin
    #12;
    chk_out(0, 0, 0, 0);
    rst = 0;
    run(4 * 256, 0, 16'h8001, 16'h7FFE);
    run(6 * 256, 1, 16'h0, 16'h0);
    run(2 * 256, 2, 16'h0, 16'h0);
    run(256, 0, 16'h8001, 16'h7FFE);
    run(to(0) + 256, 0, 16'h1234, 16'h5678);
    cyc(1, 1, 16'hAAAA, 16'h5555, 0);
    run(511, 2, 16'h0, 16'h0);
    run(to(101), 0, 16'h1234, 16'h5678);
    for (int i = 0; i < 6; i++) cyc(0, i == 2, 16'hBEEF, 16'hCAFE, 0);
    run(2 * 256 + 152, 0, 16'h8001, 16'h7FFE);
    #2 rst = 1;
    hl = 0; hr = 0; fresh = 0; m_ur = 0; n = 0;
    #1 chk_out(0, 0, 0, 0);
    #10 chk_out(0, 0, 0, 0);
    rst = 0;
    run(300, 0, 16'h8001, 16'h7FFE);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter SAMPLE_BITS, default 16, width of each channel sample word; only 16 is supported.
REQ-002 Parameter FRAME_MCLKS, default 256, mclk cycles per stereo frame; fixed at 256 (64 bclk per frame, 32 slots per channel).
REQ-003 mclk  input  1  master clock, 256x sample rate, sole clock domain.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 en  input  1  transmitter enable; low holds the block idle.
REQ-006 left_in  input  16  signed left sample (shortint).
REQ-007 right_in  input  16  signed right sample (shortint).
REQ-008 in_valid  input  1  left_in/right_in valid this cycle; written to the holding register.
REQ-009 sample_req  output  1  one-mclk pulse requesting the next sample pair.
REQ-010 underrun  output  1  sticky flag: a frame started with no fresh sample pair.
REQ-011 underrun_clr  input  1  synchronous clear of underrun.
REQ-012 bclk  output  1  I2S bit clock, mclk/4.
REQ-013 lrclk  output  1  I2S word select: 0 = left, 1 = right.
REQ-014 sdata  output  1  I2S serial data, MSB first.

Function
REQ-015 An 8-bit frame counter cnt SHALL increment by 1 per mclk while en=1 and wrap from 255 to 0.
- When en=0, cnt is forced to 0 on the next edge, including mid-frame.
REQ-016 All I2S outputs SHALL be registered and defined as functions of cnt:
- bclk = cnt[1], i.e. low for cnt mod 4 in {0,1} and high for cnt mod 4 in {2,3}.
- lrclk = cnt[7].
- The outputs follow cnt with exactly one mclk of latency.
REQ-017 Slot k = cnt[6:2] (0..31) within each half-frame:
- For k = 1..16, sdata = bit (16-k) of the active channel word: left when cnt[7]=0, right when cnt[7]=1.
- For k = 0 and k = 17..31, sdata = 0.
- This places the MSB one bclk after each lrclk transition.
REQ-018 sdata SHALL change only coincident with bclk falling (cnt mod 4 = 0), so it is stable across every bclk rising edge.
REQ-019 Holding register: in_valid=1 SHALL load left_in and right_in into holding and set fresh=1 on the same edge.
REQ-020 Frame load: on the edge where cnt wraps 255 -> 0 (and at the first edge after en rises), the shift words SHALL load from holding as it was before that edge, if fresh=1.
- If fresh=0, the shift words load 0 and underrun is set.
REQ-021 fresh SHALL be cleared by a frame load, unless in_valid=1 on the same edge; in that case the new pair is kept and fresh stays 1 for the next frame.
REQ-022 sample_req SHALL pulse high for exactly one mclk in the cycle following each frame load (cnt=0 after wrap or start); there is one pulse per frame.
REQ-023 Shift words SHALL NOT change mid-frame; in_valid mid-frame affects only holding.
REQ-024 underrun_clr SHALL clear underrun; if it coincides with a new underrun event, set wins.
REQ-025 With en=0, the block SHALL drive bclk=0, lrclk=0, sdata=0 and sample_req=0, while holding, fresh and underrun retain their values.

Reset
REQ-026 On rst=1 the block SHALL asynchronously clear:
- cnt, holding, shift words and fresh to 0;
- bclk, lrclk, sdata, sample_req and underrun to 0.
REQ-027 After rst deasserts with en=1, the first frame load SHALL occur on the first mclk edge; with fresh=0 at that point it transmits zeros and sets underrun.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with no partial-word completion.

Verification
REQ-029 Steady state:
- Stimulus: en=1; present left_in=0x8001, right_in=0x7FFE with in_valid one cycle after each sample_req.
- Response: the decoded frame gives L=0x8001 and R=0x7FFE, the MSB appears one bclk after lrclk toggles, and underrun stays 0.
REQ-030 Underrun:
- Stimulus: withhold in_valid for one frame.
- Response: that frame transmits L=R=0x0000 and underrun=1; underrun_clr then returns it to 0.
REQ-031 Coincident load and write:
- Stimulus: in_valid=1 exactly on the cnt 255->0 edge, with holding previously fresh at 0x1234/0x5678 and the new pair 0xAAAA/0x5555.
- Response: the current frame sends 0x1234/0x5678, the next frame sends 0xAAAA/0x5555, and there is no underrun.
REQ-032 Clock timing:
- Over 256 mclk there are exactly 64 bclk rising edges, lrclk period is 256 mclk, and sample_req has exactly one pulse.
- sdata never changes while bclk=1.
REQ-033 Disable and reset mid-frame:
- Stimulus: drop en at cnt=100.
- Response: outputs are 0 from the next cycle, and re-enabling restarts at cnt=0 with a frame load.
- Stimulus: assert rst asynchronously between mclk edges.
- Response: all outputs go 0 without waiting for an edge.
